lfsr_responder: RTL and testbench

LFSR_RESPONDER -- requirements
Module: lfsr_responder

---
 rtl/lfsr_responder.sv | 99 +++++++++
 tb/tb_lfsr_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_responder.sv
// LFSR responder: Galois LFSR advanced by a controller over fixed-length runs with a run-complete flag.
// Build option LFSR_RESP_LEVEL_EN: lfsr_begin is a level held through DONE instead of a one-cycle pulse.
module lfsr_responder #(
   parameter int unsigned      WIDTH   = 16,
   parameter logic [WIDTH-1:0] TAPS    = 16'hB400,
   parameter logic [WIDTH-1:0] SEED    = 16'hACE1,
   parameter int unsigned      RUN_LEN = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lfsr_reset,
   input  logic             rst,
   input  logic             en,
   output logic             lfsr_begin,
   output logic [WIDTH-1:0] lfsr_q,
   output logic [7:0]       count,
   output logic             busy
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
   localparam logic [7:0]       LAST_CNT = 8'(RUN_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             advance;
   logic             at_last;
   logic [WIDTH-1:0] lfsr_nxt;
   logic [7:0]       count_nxt;
   logic             busy_nxt;
   logic             begin_nxt;

   assign advance = en & ~rst & (state != DONE);
   assign at_last = (count == LAST_CNT);

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         lfsr_q     <= SEED_EFF;
         count      <= 8'd0;
         busy       <= 1'b0;
         lfsr_begin <= 1'b0;
      end else begin
         state      <= state_nxt;
         lfsr_q     <= lfsr_nxt;
         count      <= count_nxt;
         busy       <= busy_nxt;
         lfsr_begin <= begin_nxt;
      end
   end

   // Next-state logic; rst wins over any advance
   always_comb begin
      state_nxt = state;
      if (rst) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, RUN: begin
               if (advance) begin
                  state_nxt = at_last ? DONE : RUN;
               end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Next values of the registered outputs
   always_comb begin
      lfsr_nxt  = lfsr_q;
      count_nxt = count;
      if (lfsr_reset) begin
         lfsr_nxt = SEED_EFF;
      end else if (advance) begin
         lfsr_nxt = {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
      end
      if (rst) begin
         count_nxt = 8'd0;
      end else if (advance) begin
         count_nxt = count + 8'd1;
      end
      busy_nxt = (state_nxt == RUN);
`ifdef LFSR_RESP_LEVEL_EN
      begin_nxt = (state_nxt == DONE);
`else
      begin_nxt = (state_nxt == DONE) && (state != DONE);
`endif
   end

endmodule

// File: tb/tb_lfsr_responder.sv
// Scoreboard bench for lfsr_responder: two instances (RUN_LEN 64 and 1) share stimulus and are
// checked against a count-based reference model.
module tb_lfsr_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        lfsr_reset;
   logic        rst;
   logic        en;
   logic        begin0, begin1, busy0, busy1;
   logic [15:0] q0, q1;
   logic [7:0]  c0, c1;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0][15:0] q;
      logic [1:0][7:0]  c;
      logic [1:0]       busy;
      logic [1:0]       bgn;
   } exp_t;

   exp_t sb[$];

   localparam logic [15:0] TAPS = 16'hB400;
   localparam logic [15:0] SEED = 16'hACE1;
   int unsigned rl[2] = '{64, 1};
   logic [15:0] m_q[2];
   int unsigned m_c[2];

   always #5 clk = ~clk;

   lfsr_responder #(.WIDTH(16), .TAPS(TAPS), .SEED(SEED), .RUN_LEN(64)) u_dut0 (
      .clk(clk), .reset(reset), .lfsr_reset(lfsr_reset), .rst(rst), .en(en),
      .lfsr_begin(begin0), .lfsr_q(q0), .count(c0), .busy(busy0));

   lfsr_responder #(.WIDTH(16), .TAPS(TAPS), .SEED(SEED), .RUN_LEN(1)) u_dut1 (
      .clk(clk), .reset(reset), .lfsr_reset(lfsr_reset), .rst(rst), .en(en),
      .lfsr_begin(begin1), .lfsr_q(q1), .count(c1), .busy(busy1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic [15:0] r;
      r = v / 16'd2;
      if (v % 16'd2 == 16'd1) r = r ^ TAPS;
      return r;
   endfunction

   // Reference model: run state is implied by the count (0 idle, 1..RUN_LEN-1 running, RUN_LEN done)
   task automatic cycle(input bit e, input bit r, input bit l);
      exp_t        x;
      bit          adv;
      int unsigned old_c;
      @(negedge clk);
      en = e; rst = r; lfsr_reset = l;
      for (int i = 0; i < 2; i++) begin
         old_c = m_c[i];
         adv   = e && !r && (m_c[i] != rl[i]);
         if (l)        m_q[i] = SEED;
         else if (adv) m_q[i] = lfsr_step(m_q[i]);
         if (r)        m_c[i] = 0;
         else if (adv) m_c[i] = m_c[i] + 1;
         x.q[i]    = m_q[i];
         x.c[i]    = 8'(m_c[i]);
         x.busy[i] = (m_c[i] > 0) && (m_c[i] < rl[i]);
`ifdef LFSR_RESP_LEVEL_EN
         x.bgn[i]  = (m_c[i] == rl[i]);
`else
         x.bgn[i]  = (m_c[i] == rl[i]) && (old_c != rl[i]);
`endif
      end
      sb.push_back(x);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_q0"}, 32'(q0), 32'(SEED));
      chk({tag, "_c0"}, 32'(c0), 32'd0);
      chk({tag, "_busy0"}, 32'(busy0), 32'd0);
      chk({tag, "_begin0"}, 32'(begin0), 32'd0);
      chk({tag, "_q1"}, 32'(q1), 32'(SEED));
      chk({tag, "_begin1"}, 32'(begin1), 32'd0);
   endtask

   // Asynchronous reset asserted and released between clock edges
   task automatic async_reset();
      @(negedge clk);
      en = 1'b0; rst = 1'b0; lfsr_reset = 1'b0;
      #2 reset = 1'b1;
      #1 check_reset_values("async_reset");
      for (int i = 0; i < 2; i++) begin
         m_q[i] = SEED;
         m_c[i] = 0;
      end
      #1 reset = 1'b0;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   // Monitor: each cycle with an outstanding expectation is compared just after the edge
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("q0", 32'(q0), 32'(x.q[0]));
            chk("count0", 32'(c0), 32'(x.c[0]));
            chk("busy0", 32'(busy0), 32'(x.busy[0]));
            chk("begin0", 32'(begin0), 32'(x.bgn[0]));
            chk("q1", 32'(q1), 32'(x.q[1]));
            chk("count1", 32'(c1), 32'(x.c[1]));
            chk("busy1", 32'(busy1), 32'(x.busy[1]));
            chk("begin1", 32'(begin1), 32'(x.bgn[1]));
         end
      end
   end

   initial begin
      reset = 1'b1; lfsr_reset = 1'b0; rst = 1'b0; en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_q[i] = SEED;
         m_c[i] = 0;
      end
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;

      // First two advances from the seed
      cycle(1, 0, 0);
      after_edge();
      chk("first_q", 32'(q0), 32'h0000E270);
      chk("first_count", 32'(c0), 32'd1);
      chk("first_busy", 32'(busy0), 32'd1);
      cycle(1, 0, 0);
      after_edge();
      chk("second_q", 32'(q0), 32'h00007138);
      chk("second_count", 32'(c0), 32'd2);

      // Full run with en held, plus extra en cycles while done
      cycle(0, 1, 0);
      repeat (70) cycle(1, 0, 0);
      after_edge();
      chk("run_count", 32'(c0), 32'd64);
      chk("run_busy", 32'(busy0), 32'd0);

      // Pause at count 10
      cycle(0, 1, 0);
      repeat (10) cycle(1, 0, 0);
      repeat (5) cycle(0, 0, 0);
      cycle(1, 0, 0);
      after_edge();
      chk("resume_count", 32'(c0), 32'd11);

      // Reload with en, then rst with en
      cycle(0, 1, 0);
      repeat (3) cycle(1, 0, 0);
      cycle(1, 0, 1);
      after_edge();
      chk("reload_q", 32'(q0), 32'(SEED));
      chk("reload_count", 32'(c0), 32'd4);
      cycle(1, 1, 0);
      after_edge();
      chk("rst_count", 32'(c0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);

      // Async reset mid-run at count 30, then no run-complete flag afterwards
      repeat (30) cycle(1, 0, 0);
      async_reset();
      repeat (8) cycle(0, 0, 0);
      repeat (5) cycle(1, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cycle($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3);
      end

      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
